// File: rtl/core_dmem_arbiter_pkg.sv
// Package for the dmem arbiter slice: pulls in the shared width and owner
// constants and adds a small owner helper.
package core_dmem_arbiter_pkg;

`include "core_common.svh"

    // The requester that is not 'o'; the owner encoding is one bit wide.
    function automatic logic other_owner(input logic o);
        return (o == OWN_A) ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/core_common.svh
// Shared constants for the core data-memory path.
//   CORE_ADDR_W / CORE_DATA_W : default address and data widths
//   CORE_STRB_W               : default write-strobe width (one strobe per byte)
//   CORE_BYTE_W               : data bits covered by one strobe bit
//   OWN_A / OWN_B             : 1-bit encoding of the two requesters
// This header is included inside core_dmem_arbiter_pkg, so it carries no
// include guard of its own.
localparam int unsigned CORE_ADDR_W = 64;
localparam int unsigned CORE_DATA_W = 64;
localparam int unsigned CORE_STRB_W = CORE_DATA_W / 8;
localparam int unsigned CORE_BYTE_W = CORE_DATA_W / CORE_STRB_W;
localparam logic        OWN_A       = 1'b0;
localparam logic        OWN_B       = 1'b1;

// File: rtl/core_rr_arb2.sv
// Two-way round-robin pick with lock override, purely combinational.
// Ports:
//   a_req, b_req : current-cycle requests
//   rr_last      : requester granted most recently
//   lock         : a stalled request is being held
//   lock_owner   : requester that holds the lock
//   owner        : selected requester (OWN_A when nobody requests)
module core_rr_arb2
    import core_dmem_arbiter_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic rr_last,
    input  logic lock,
    input  logic lock_owner,
    output logic owner
);

    logic lock_owner_req;

    always_comb begin
        lock_owner_req = (lock_owner == OWN_A) ? a_req : b_req;
        owner          = OWN_A;
        // A lock whose owner has dropped its request is simply ignored.
        if (lock && lock_owner_req) begin
            owner = lock_owner;
        end else if (a_req && b_req) begin
            owner = other_owner(rr_last);
        end else if (b_req) begin
            owner = OWN_B;
        end else begin
            owner = OWN_A;
        end
    end

endmodule

// File: rtl/core_dmem_arbiter.sv
// Arbitrates two data-memory requesters (A, B) onto one downstream port.
// Selection is combinational, so grants add no latency; a stalled request
// is locked so it cannot be pre-empted; responses arrive one cycle after
// the handshake and the error is steered to the requester that owned it.
// Ports:
//   g_clk, g_reset               : clock, synchronous active-high reset
//   a_* / b_*                    : requester request fields, grant, err, rdata
//   m_req, m_wen, m_addr,
//   m_strb, m_wdata              : shared downstream request
//   m_gnt, m_err, m_rdata        : downstream grant and response
//   busy                         : a response is due or a lock is held
module core_dmem_arbiter
    import core_dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = CORE_ADDR_W,
    parameter int unsigned DATA_W = CORE_DATA_W,
    parameter int unsigned STRB_W = DATA_W / CORE_BYTE_W
) (
    input  logic              g_clk,
    input  logic              g_reset,

    input  logic              a_req,
    input  logic              a_wen,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [STRB_W-1:0] a_strb,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_wen,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [STRB_W-1:0] b_strb,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,

    output logic              m_req,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [STRB_W-1:0] m_strb,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_err,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              busy
);

    logic lock_q,       lock_d;
    logic lock_owner_q, lock_owner_d;
    logic rr_last_q,    rr_last_d;
    logic rsp_valid_q,  rsp_valid_d;
    logic rsp_owner_q,  rsp_owner_d;

    logic owner;
    logic hs;

    core_rr_arb2 u_rr_arb2 (
        .a_req      (a_req),
        .b_req      (b_req),
        .rr_last    (rr_last_q),
        .lock       (lock_q),
        .lock_owner (lock_owner_q),
        .owner      (owner)
    );

    // Downstream mux; with no request the owner is A, so A's fields show.
    always_comb begin
        if (owner == OWN_A) begin
            m_req   = a_req;
            m_wen   = a_wen;
            m_addr  = a_addr;
            m_strb  = a_strb;
            m_wdata = a_wdata;
        end else begin
            m_req   = b_req;
            m_wen   = b_wen;
            m_addr  = b_addr;
            m_strb  = b_strb;
            m_wdata = b_wdata;
        end
    end

    assign hs    = m_req && m_gnt;
    assign a_gnt = m_gnt && (owner == OWN_A) && a_req;
    assign b_gnt = m_gnt && (owner == OWN_B) && b_req;

    always_comb begin
        // A stall (re)locks onto whoever owns the bus now; a handshake, an
        // idle bus or a dropped locked request all leave the lock clear.
        lock_d       = m_req && !m_gnt;
        lock_owner_d = (m_req && !m_gnt) ? owner : lock_owner_q;
        rr_last_d    = hs ? owner : rr_last_q;
        rsp_valid_d  = hs;
        rsp_owner_d  = hs ? owner : rsp_owner_q;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_A;
            rr_last_q    <= OWN_B;
            rsp_valid_q  <= 1'b0;
            rsp_owner_q  <= OWN_A;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            rr_last_q    <= rr_last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_owner_q  <= rsp_owner_d;
        end
    end

    // Response side: read data is broadcast, the error goes to the owner
    // of the previous cycle's handshake. Reset masks err and busy at once
    // so a response pending when reset hits is never delivered.
    assign a_rdata = m_rdata;
    assign b_rdata = m_rdata;
    assign a_err   = !g_reset && m_err && rsp_valid_q && (rsp_owner_q == OWN_A);
    assign b_err   = !g_reset && m_err && rsp_valid_q && (rsp_owner_q == OWN_B);
    assign busy    = !g_reset && (rsp_valid_q || lock_q);

endmodule

// File: doc/core_dmem_arbiter.md
CORE_DMEM_ARBITER -- requirements
Module: core_dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data width.
REQ-003 SHALL have parameter STRB_W, default DATA_W/8, meaning write strobe width.
REQ-004 SHALL have port g_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port g_reset, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have ports a_req, a_wen, inputs, 1 each: requester A request and write enable.
REQ-007 SHALL have ports a_addr, a_strb, a_wdata, inputs, ADDR_W/STRB_W/DATA_W: requester A request fields.
REQ-008 SHALL have ports a_gnt, a_err, outputs, 1 each, plus a_rdata, output, DATA_W: requester A grant and response.
REQ-009 SHALL have the B-requester set b_req, b_wen, b_addr, b_strb, b_wdata, b_gnt, b_err, b_rdata, identical to REQ-006..008.
REQ-010 SHALL have ports m_req, m_wen, outputs, 1, and m_addr, m_strb, m_wdata, outputs, ADDR_W/STRB_W/DATA_W: shared downstream dmem request.
REQ-011 SHALL have ports m_gnt, m_err, inputs, 1, and m_rdata, input, DATA_W: downstream grant and response.
REQ-012 SHALL have port busy, output, 1: a response is due this cycle, or a lock is held.

Function
REQ-013 Bus protocol SHALL be: request accepted in the cycle where req && gnt; err/rdata valid exactly one cycle later, with no valid strobe.
REQ-014 Selection SHALL be combinational from the current-cycle request inputs, lock state and rr state; grant SHALL be in the same cycle as m_gnt, with zero added latency.
REQ-015 If the lock is held and the locked owner's req is high, owner = locked owner.
REQ-016 Otherwise, if only one req is high, owner = that requester.
REQ-017 Otherwise, if both reqs are high, owner = the requester not granted most recently (round-robin register rr_last).
REQ-018 Otherwise, with no req high, m_req = 0 and the request fields SHALL be driven from A.
REQ-019 The arbiter SHALL drive m_req = owner's req and m_addr/m_wen/m_strb/m_wdata = owner's fields.
REQ-020 Grants SHALL be a_gnt = m_gnt && owner==A && a_req, and b_gnt likewise for B; a_gnt and b_gnt SHALL never both be 1.
REQ-021 Lock SHALL set (owner recorded) when m_req && !m_gnt: a stalled request is not pre-empted.
REQ-022 Lock SHALL clear on m_req && m_gnt.
REQ-023 If the locked owner drops req without a grant (protocol violation), the lock SHALL be ignored and cleared that cycle, and fresh arbitration applies.
REQ-024 rr_last SHALL update to owner on every m_req && m_gnt.
REQ-025 rsp_valid SHALL be registered as m_req && m_gnt, and rsp_owner SHALL be registered as owner on that handshake.
REQ-026 a_rdata and b_rdata SHALL both equal m_rdata (broadcast).
REQ-027 Error steering SHALL be a_err = m_err && rsp_valid && rsp_owner==A, and b_err likewise.
REQ-028 Back-to-back handshakes (one per cycle, alternating owners) SHALL be supported; the response routing of cycle N SHALL be unaffected by arbitration in cycle N+1.
REQ-029 busy SHALL equal rsp_valid || lock.

Reset
REQ-030 While g_reset = 1 at a clock edge: lock <= 0, rsp_valid <= 0, rsp_owner <= A, and rr_last <= B, so A wins the first contention.
REQ-031 During and after reset, the outputs SHALL be: a_err = b_err = 0, busy = 0, and m_req equal to the current OR of the qualified reqs (combinational).
REQ-032 Reset during a locked stall or a pending response SHALL discard both; no err is delivered in the following cycle.

Structure
REQ-033 ADDR/DATA/STRB width constants and the 1-bit owner encoding (OWN_A = 0, OWN_B = 1) SHALL live in the shared core_common.svh header.
REQ-034 The 2-way round-robin pick (reqs, rr_last, lock, locked owner -> owner) SHALL be sub-module core_rr_arb2, purely combinational.
REQ-035 All registers (lock, lock_owner, rr_last, rsp_valid, rsp_owner) SHALL reside in core_dmem_arbiter.

Verification
REQ-036 Directed scenario: after reset, a_req = b_req = 1 and m_gnt = 1 for 4 cycles -> grants A, B, A, B; a_rdata/b_rdata = m_rdata, and the err of each response is seen only by its owner.
REQ-037 Directed scenario: b_req = 1 with m_gnt = 0 for 3 cycles while a_req rises in cycle 2 -> m_addr stays at B's address, and on m_gnt = 1 b_gnt = 1 and a_gnt = 0; A is granted the next cycle.
REQ-038 Directed scenario: A is granted with m_err = 1 in the following cycle -> a_err = 1, b_err = 0; m_err = 1 with no prior handshake -> both errs 0.
REQ-039 Directed scenario: g_reset = 1 asserted one cycle after an A handshake -> a_err = 0 in the response cycle; the next contention is won by A.
REQ-040 Directed scenario: locked owner B drops b_req while a_req = 1 -> m_req follows A in the same cycle and lock clears.
REQ-041 Directed scenario: a random 10k-cycle run with a stalling downstream -> checks that grants are never simultaneous, no request starves for more than 1 competing grant, and each response is routed to its requester.
